// File: rtl/permutation_iter.sv
// Iterative Ascon permutation p^N: one pC -> pS -> pL round per clock on the
// 320-bit state (x0 in bits 319:256 down to x4 in bits 63:0).
module permutation_iter #(
    parameter int MAX_ROUNDS = 12
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic [3:0]   nb_rounds_i,
    input  logic [319:0] state_i,
    output logic         ready_o,
    output logic         valid_o,
    output logic         error_o,
    output logic [3:0]   round_o,
    output logic [319:0] state_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    localparam logic [3:0] MAX_R  = 4'(MAX_ROUNDS);
    localparam logic [3:0] LAST_R = 4'(MAX_ROUNDS - 1);

    fsm_t           fsm_r;
    fsm_t           fsm_next_s;
    logic [319:0]   state_r;
    logic [319:0]   state_next_s;
    logic [3:0]     round_r;
    logic [3:0]     round_next_s;
    logic           valid_r;
    logic           valid_next_s;
    logic           error_r;
    logic           error_next_s;
    logic           legal_s;

    function automatic logic [4:0] sbox(input logic [4:0] v);
        case (v)
            5'd0:  sbox = 5'h04;  5'd1:  sbox = 5'h0B;  5'd2:  sbox = 5'h1F;  5'd3:  sbox = 5'h14;
            5'd4:  sbox = 5'h1A;  5'd5:  sbox = 5'h15;  5'd6:  sbox = 5'h09;  5'd7:  sbox = 5'h02;
            5'd8:  sbox = 5'h1B;  5'd9:  sbox = 5'h05;  5'd10: sbox = 5'h08;  5'd11: sbox = 5'h12;
            5'd12: sbox = 5'h1D;  5'd13: sbox = 5'h03;  5'd14: sbox = 5'h06;  5'd15: sbox = 5'h1C;
            5'd16: sbox = 5'h1E;  5'd17: sbox = 5'h13;  5'd18: sbox = 5'h07;  5'd19: sbox = 5'h0E;
            5'd20: sbox = 5'h00;  5'd21: sbox = 5'h0D;  5'd22: sbox = 5'h11;  5'd23: sbox = 5'h18;
            5'd24: sbox = 5'h10;  5'd25: sbox = 5'h0C;  5'd26: sbox = 5'h01;  5'd27: sbox = 5'h19;
            5'd28: sbox = 5'h16;  5'd29: sbox = 5'h0A;  5'd30: sbox = 5'h0F;  5'd31: sbox = 5'h17;
            default: sbox = 5'h00;
        endcase
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] v, input int unsigned n);
        ror = (v >> n) | (v << (32'd64 - n));
    endfunction

    function automatic logic [319:0] round_fn(input logic [319:0] s, input logic [3:0] r);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  col;
        for (int i = 0; i < 5; i++) begin
            x[i] = s[319 - 64*i -: 64];
        end
        x[2][7:0] = x[2][7:0] ^ {~r, r};
        // Bit-sliced substitution: column j gathers bit j of every word, x0 as MSB.
        for (int j = 0; j < 64; j++) begin
            col     = sbox({x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]});
            y[0][j] = col[4];
            y[1][j] = col[3];
            y[2][j] = col[2];
            y[3][j] = col[1];
            y[4][j] = col[0];
        end
        x[0] = y[0] ^ ror(y[0], 32'd19) ^ ror(y[0], 32'd28);
        x[1] = y[1] ^ ror(y[1], 32'd61) ^ ror(y[1], 32'd39);
        x[2] = y[2] ^ ror(y[2], 32'd1)  ^ ror(y[2], 32'd6);
        x[3] = y[3] ^ ror(y[3], 32'd10) ^ ror(y[3], 32'd17);
        x[4] = y[4] ^ ror(y[4], 32'd7)  ^ ror(y[4], 32'd41);
        round_fn = {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    assign legal_s = (nb_rounds_i != 4'd0) && (nb_rounds_i <= MAX_R);

    // FSM state register.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            fsm_r <= IDLE;
        end else begin
            fsm_r <= fsm_next_s;
        end
    end

    // Next-state logic: the run ends on the edge that applies the last constant index.
    always_comb begin
        fsm_next_s = fsm_r;
        case (fsm_r)
            IDLE: begin
                if (start_i && legal_s) fsm_next_s = RUN;
                else                    fsm_next_s = IDLE;
            end
            RUN: begin
                if (round_r == LAST_R) fsm_next_s = IDLE;
                else                   fsm_next_s = RUN;
            end
            default: fsm_next_s = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        state_next_s = state_r;
        round_next_s = round_r;
        valid_next_s = 1'b0;
        error_next_s = 1'b0;
        case (fsm_r)
            IDLE: begin
                if (start_i) begin
                    if (legal_s) begin
                        state_next_s = state_i;
                        round_next_s = MAX_R - nb_rounds_i;
                    end else begin
                        error_next_s = 1'b1;
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            RUN: begin
                state_next_s = round_fn(state_r, round_r);
                round_next_s = round_r + 4'd1;
                valid_next_s = (round_r == LAST_R);
            end
            default: begin
                state_next_s = state_r;
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= 320'd0;
            round_r <= 4'd0;
            valid_r <= 1'b0;
            error_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            round_r <= round_next_s;
            valid_r <= valid_next_s;
            error_r <= error_next_s;
        end
    end

    assign ready_o = (fsm_r == IDLE);
    assign valid_o = valid_r;
    assign error_o = error_r;
    assign round_o = round_r;
    assign state_o = state_r;

endmodule
